// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store side of the data-memory path:
// store op codes (same codes the load lane extractor decodes) and the
// layout of one queued store entry.
package store_buffer_pkg;

    // MEM-stage store op codes
    localparam logic [7:0] EXE_SB_OP = 8'b0010_1000;
    localparam logic [7:0] EXE_SH_OP = 8'b0010_1001;
    localparam logic [7:0] EXE_SW_OP = 8'b0010_1011;

    // One formatted store waiting to be written to the data SRAM
    typedef struct packed {
        logic [29:0] word;   // byte address [31:2]
        logic [3:0]  wen;    // big-endian byte mask, bit3 = wdata[31:24]
        logic [31:0] wdata;  // lane-replicated write data
    } sb_entry_t;

    // True for the three op codes this buffer accepts
    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/store_buffer_format.sv
// Combinational store formatter: turns op/addr/data into a byte-write mask,
// lane-replicated write data and a misalignment flag. Lanes are big-endian,
// mirroring the load path.
module store_buffer_format
    import store_buffer_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  wen,
    output logic [31:0] wdata
);

    // Decode the op and select lanes from the low address bits
    always_comb begin
        is_store   = is_store_op(op);
        misaligned = 1'b0;
        wen        = 4'b0000;
        wdata      = 32'h0000_0000;
        case (op)
            EXE_SB_OP: begin
                wdata = {4{data[7:0]}};
                case (addr[1:0])
                    2'b00:   wen = 4'b1000;
                    2'b01:   wen = 4'b0100;
                    2'b10:   wen = 4'b0010;
                    default: wen = 4'b0001;
                endcase
            end
            EXE_SH_OP: begin
                wdata      = {2{data[15:0]}};
                misaligned = addr[0];
                wen        = addr[0] ? 4'b0000 : (addr[1] ? 4'b0011 : 4'b1100);
            end
            EXE_SW_OP: begin
                wdata      = data;
                misaligned = (addr[1:0] != 2'b00);
                wen        = misaligned ? 4'b0000 : 4'b1111;
            end
            default: begin
                is_store = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: formats MEM-stage stores, queues them in a small FIFO and
// drains the head entry to the data SRAM over a req/ack handshake. Loads
// that touch the word of any pending store are flagged through ld_hit.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [7:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        ades,
    output logic [31:0] ades_badvaddr,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        sb_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Queue state
    sb_entry_t          entry_reg [DEPTH];
    logic [DEPTH-1:0]   entry_valid_reg;
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               ades_reg;
    logic [31:0]        ades_badvaddr_reg;

    // Formatter results for the incoming store
    logic        fmt_is_store;
    logic        fmt_misaligned;
    logic [3:0]  fmt_wen;
    logic [31:0] fmt_wdata;

    logic             enq;
    logic             deq;
    logic             ades_next;
    logic [DEPTH-1:0] hit_vec;
    sb_entry_t        head_entry;

    store_buffer_format u_format (
        .op         (st_op),
        .addr       (st_addr),
        .data       (st_data),
        .is_store   (fmt_is_store),
        .misaligned (fmt_misaligned),
        .wen        (fmt_wen),
        .wdata      (fmt_wdata)
    );

    // Full depends only on the count, so an ack in the same cycle never
    // opens a slot for a new store (no bypass through a full buffer).
    assign st_ready  = (count_reg < DEPTH_CNT);
    assign enq       = st_valid & st_ready & fmt_is_store & ~fmt_misaligned;
    assign deq       = mem_req & mem_ack;
    assign ades_next = st_valid & fmt_is_store & fmt_misaligned;

    // Head entry drives the SRAM request; it only changes on deq or reset,
    // so the request stays stable while waiting for an ack.
    assign head_entry = entry_reg[head_reg];
    assign mem_req    = entry_valid_reg[head_reg];
    assign mem_wen    = mem_req ? head_entry.wen : 4'b0000;
    assign mem_addr   = {head_entry.word, 2'b00};
    assign mem_wdata  = head_entry.wdata;
    assign sb_empty   = (count_reg == '0);

    assign ades          = ades_reg;
    assign ades_badvaddr = ades_badvaddr_reg;

    // Per-entry word match against the load address, gated by valid
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = entry_valid_reg[gi] &&
                                 (entry_reg[gi].word == ld_addr[31:2]);
        end
    endgenerate

    assign ld_hit = |hit_vec;

    // Entry payload write at the tail; payload needs no reset since valid gates it
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_reg[tail_reg] <= '{word: st_addr[31:2], wen: fmt_wen, wdata: fmt_wdata};
        end
    end

    // Valid bits, pointers and count; reset discards every pending store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid_reg <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            if (deq) begin
                entry_valid_reg[head_reg] <= 1'b0;
                head_reg                  <= head_reg + PTR_W'(1);
            end
            if (enq) begin
                entry_valid_reg[tail_reg] <= 1'b1;
                tail_reg                  <= tail_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Misaligned-store exception: one-cycle pulse, address held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ades_reg          <= 1'b0;
            ades_badvaddr_reg <= 32'h0000_0000;
        end else begin
            ades_reg <= ades_next;
            if (ades_next) begin
                ades_badvaddr_reg <= st_addr;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by a
// randomized run compared against a queue-based reference model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [7:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ades;
    logic [31:0] ades_badvaddr;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        sb_empty;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } model_t;

    model_t mq[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_op         (st_op),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_ready      (st_ready),
        .ades          (ades),
        .ades_badvaddr (ades_badvaddr),
        .mem_req       (mem_req),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .ld_addr       (ld_addr),
        .ld_hit        (ld_hit),
        .sb_empty      (sb_empty)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_op = 8'h00; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL reset_sb_empty got=%0b exp=1", sb_empty); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%0b exp=1", st_ready); end
        checks++; if (ades !== 1'b0 || ades_badvaddr !== 32'h0) begin failures++; $display("FAIL reset_ades got=%0b/%h exp=0/00000000", ades, ades_badvaddr); end
        checks++; if (mem_wen !== 4'b0 || ld_hit !== 1'b0) begin failures++; $display("FAIL reset_wen_hit got=%b/%0b exp=0000/0", mem_wen, ld_hit); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sb();
        st_valid = 1'b1; st_op = EXE_SB_OP; st_addr = 32'h1003; st_data = 32'h0000_00AB; mem_ack = 1'b1;
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_wen !== 4'b0001) begin failures++; $display("FAIL sb_req_wen got=%0b/%b exp=1/0001", mem_req, mem_wen); end
        checks++; if (mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h1000) begin failures++; $display("FAIL sb_data_addr got=%h/%h exp=ababbabab/00001000", mem_wdata, mem_addr); end
        tick();
        checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin failures++; $display("FAIL sb_drained got=%0b/%0b exp=0/1", mem_req, sb_empty); end
        mem_ack = 1'b0;
    endtask

    task automatic test_sh();
        st_valid = 1'b1; st_op = EXE_SH_OP; st_addr = 32'h2000; st_data = 32'hFFFF_1234;
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (mem_wen !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin failures++; $display("FAIL sh_format got=%b/%h exp=1100/12341234", mem_wen, mem_wdata); end
        tick();
        checks++; if (mem_wen !== 4'b1100 || mem_addr !== 32'h2000) begin failures++; $display("FAIL sh_stable got=%b/%h exp=1100/00002000", mem_wen, mem_addr); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL sh_drained got=%0b exp=1", sb_empty); end
    endtask

    task automatic test_ades(input logic [7:0] op, input logic [31:0] addr, input string name);
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = 32'hDEAD_BEEF;
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (ades !== 1'b1 || ades_badvaddr !== addr) begin failures++; $display("FAIL %s_pulse got=%0b/%h exp=1/%h", name, ades, ades_badvaddr, addr); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL %s_no_req got=%0b exp=0", name, mem_req); end
        tick();
        checks++; if (ades !== 1'b0 || ades_badvaddr !== addr || sb_empty !== 1'b1) begin failures++; $display("FAIL %s_after got=%0b/%h/%0b exp=0/%h/1", name, ades, ades_badvaddr, sb_empty, addr); end
    endtask

    task automatic test_full();
        mem_ack = 1'b0;
        st_valid = 1'b1; st_op = EXE_SW_OP; st_addr = 32'h10; st_data = 32'h1111_1111;
        tick();
        st_addr = 32'h14; st_data = 32'h2222_2222;
        tick();
        st_addr = 32'h18; st_data = 32'h3333_3333;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", st_ready); end
        mem_ack = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%0b exp=0", st_ready); end
        mem_ack = 1'b0;
        tick();
        st_valid = 1'b0;
        checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h1111_1111) begin failures++; $display("FAIL full_head0 got=%h/%h exp=00000010/11111111", mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        tick();
        checks++; if (mem_addr !== 32'h14 || mem_wdata !== 32'h2222_2222 || mem_req !== 1'b1) begin failures++; $display("FAIL full_head1 got=%h/%h/%0b exp=00000014/22222222/1", mem_addr, mem_wdata, mem_req); end
        tick();
        mem_ack = 1'b0;
        checks++; if (sb_empty !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b/%0b exp=1/0", sb_empty, mem_req); end
    endtask

    task automatic test_ld_hit();
        st_valid = 1'b1; st_op = EXE_SW_OP; st_addr = 32'h40; st_data = 32'h5555_AAAA; mem_ack = 1'b0;
        ld_addr = 32'h42;
        #1;
        checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_before_enq got=%0b exp=0", ld_hit); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (ld_hit !== 1'b1) begin failures++; $display("FAIL ldhit_same_word got=%0b exp=1", ld_hit); end
        ld_addr = 32'h44;
        #1;
        checks++; if (ld_hit !== 1'b0) begin failures++; $display("FAIL ldhit_next_word got=%0b exp=0", ld_hit); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_addr = 32'h40;
        #1;
        checks++; if (ld_hit !== 1'b0 || sb_empty !== 1'b1) begin failures++; $display("FAIL ldhit_drained got=%0b/%0b exp=0/1", ld_hit, sb_empty); end
    endtask

    task automatic test_reset_mid_drain();
        st_valid = 1'b1; st_op = EXE_SW_OP; st_addr = 32'h80; st_data = 32'h1;
        tick();
        st_addr = 32'h84; st_data = 32'h2;
        tick();
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || st_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%0b/%0b exp=1/0", mem_req, st_ready); end
        mem_ack = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1 || mem_wen !== 4'b0) begin failures++; $display("FAIL midrst_async got=%0b/%0b/%b exp=0/1/0000", mem_req, sb_empty, mem_wen); end
        checks++; if (ades_badvaddr !== 32'h0) begin failures++; $display("FAIL midrst_badvaddr got=%h exp=00000000", ades_badvaddr); end
        #1;
        rst = 1'b0;
        tick();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin failures++; $display("FAIL midrst_after got=%0b/%0b exp=0/1", mem_req, sb_empty); end
    endtask

    // Randomized traffic against a queue model built from the lane rules
    task automatic test_random(input int cycles);
        logic [31:0] exp_badvaddr;
        logic        exp_ades;
        logic        legal, aligned, exp_hit, enq, deq;
        logic [3:0]  m_wen;
        logic [31:0] m_wdata;
        int          r, sh;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mq.delete();
        exp_badvaddr = 32'h0;
        for (int c = 0; c < cycles; c++) begin
            r        = int'($urandom_range(0, 3));
            st_op    = (r == 0) ? EXE_SB_OP : (r == 1) ? EXE_SH_OP : (r == 2) ? EXE_SW_OP : 8'h00;
            st_valid = ($urandom_range(0, 99) < 60);
            st_addr  = 32'h100 + 32'($urandom_range(0, 31));
            st_data  = $urandom;
            mem_ack  = ($urandom_range(0, 99) < 45);
            ld_addr  = 32'h100 + 32'($urandom_range(0, 31));
            #1;
            exp_hit = 1'b0;
            foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) exp_hit = 1'b1;
            checks++; if (ld_hit !== exp_hit) begin failures++; $display("FAIL rnd_ld_hit cyc=%0d got=%0b exp=%0b", c, ld_hit, exp_hit); end
            checks++; if (st_ready !== (mq.size() < DEPTH) || mem_req !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_ready_req cyc=%0d got=%0b/%0b exp=%0b/%0b", c, st_ready, mem_req, mq.size() < DEPTH, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if (mem_addr !== mq[0].addr || mem_wen !== mq[0].wen || mem_wdata !== mq[0].wdata) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%b/%h exp=%h/%b/%h", c, mem_addr, mem_wen, mem_wdata, mq[0].addr, mq[0].wen, mq[0].wdata); end
            end else begin
                checks++; if (mem_wen !== 4'b0) begin failures++; $display("FAIL rnd_idle_wen cyc=%0d got=%b exp=0000", c, mem_wen); end
            end
            legal = (r != 3);
            sh    = 3 - int'(st_addr[1:0]);
            case (r)
                0: begin aligned = 1'b1; m_wen = 4'(1 << sh); m_wdata = {24'h0, st_data[7:0]} * 32'h0101_0101; end
                1: begin aligned = (st_addr[0] == 1'b0); m_wen = st_addr[1] ? 4'b0011 : 4'b1100; m_wdata = {16'h0, st_data[15:0]} * 32'h0001_0001; end
                default: begin aligned = (st_addr[1:0] == 2'b00); m_wen = 4'b1111; m_wdata = st_data; end
            endcase
            enq      = st_valid && legal && aligned && (mq.size() < DEPTH);
            deq      = (mq.size() > 0) && mem_ack;
            exp_ades = st_valid && legal && !aligned;
            if (exp_ades) exp_badvaddr = st_addr;
            tick();
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back('{addr: {st_addr[31:2], 2'b00}, wen: m_wen, wdata: m_wdata});
            checks++; if (ades !== exp_ades || ades_badvaddr !== exp_badvaddr) begin failures++; $display("FAIL rnd_ades cyc=%0d got=%0b/%h exp=%0b/%h", c, ades, ades_badvaddr, exp_ades, exp_badvaddr); end
            checks++; if (sb_empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%0b exp=%0b", c, sb_empty, mq.size() == 0); end
        end
        st_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_ades(EXE_SW_OP, 32'h2002, "ades_sw");
        test_ades(EXE_SH_OP, 32'h2001, "ades_sh");
        test_full();
        test_ld_hit();
        test_reset_mid_drain();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
